snake_timing_input_food: RTL and testbench

- Support block for the snake game, in the MasterClock domain.
- Generates three divided square-wave clocks (pixel/debounce, game tick, 7-seg refresh).
- Debounces the five push-buttons, producing one-cycle press pulses.
- Continuously proposes a random empty grid cell for the next food item from the packed block grid.

---
 rtl/snake_timing_input_food.sv | 158 +++++++++++++++
 tb/tb_snake_timing_input_food.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/snake_timing_input_food.sv
// Snake game support block: divided clocks, button debouncers with press pulses,
// and an LFSR-driven proposer of an empty grid cell for the next food item.
module snake_timing_input_food #(
    parameter int unsigned PIX_DIV         = 4,
    parameter int unsigned GAME_DIV        = 10000000,
    parameter int unsigned FAST_DIV        = 200000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned GRID_WIDTH      = 32,
    parameter int unsigned GRID_HEIGHT     = 24,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                                  MasterClock,
    input  logic                                  ResetN,
    input  logic                                  ButtonLeft,
    input  logic                                  ButtonRight,
    input  logic                                  ButtonUp,
    input  logic                                  ButtonDown,
    input  logic                                  ButtonCenter,
    input  logic [2*GRID_WIDTH*GRID_HEIGHT-1:0]   Blocks,
    output logic                                  DebounceClock,
    output logic                                  GameClock,
    output logic                                  FastClock,
    output logic                                  LeftPressed,
    output logic                                  RightPressed,
    output logic                                  UpPressed,
    output logic                                  DownPressed,
    output logic                                  CenterPressed,
    output logic                                  LeftLevel,
    output logic                                  RightLevel,
    output logic                                  UpLevel,
    output logic                                  DownLevel,
    output logic                                  CenterLevel,
    output logic [$clog2(GRID_HEIGHT)-1:0]        NextFoodV,
    output logic [$clog2(GRID_WIDTH)-1:0]         NextFoodH,
    output logic                                  NextFoodValid
);

    localparam int unsigned VW = $clog2(GRID_HEIGHT);
    localparam int unsigned HW = $clog2(GRID_WIDTH);
    localparam int unsigned BW = $clog2(2*GRID_WIDTH*GRID_HEIGHT);
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [2:0] div_clk;
    logic [4:0] raw_btn;
    logic [4:0] level;
    logic [4:0] press;

    // Each divider toggles its output every DIV/2 cycles.
    for (genvar g = 0; g < 3; g++) begin : g_div
        localparam int unsigned HALF = (g == 0) ? PIX_DIV/2 : (g == 1) ? GAME_DIV/2 : FAST_DIV/2;
        localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;
        logic [CW-1:0] cnt_q;
        logic          clk_q;

        always_ff @(posedge MasterClock or negedge ResetN) begin
            if (!ResetN) begin
                cnt_q <= '0;
                clk_q <= 1'b0;
            end else if (cnt_q == CW'(HALF-1)) begin
                cnt_q <= '0;
                clk_q <= ~clk_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign div_clk[g] = clk_q;
    end

    assign raw_btn = {ButtonCenter, ButtonDown, ButtonUp, ButtonRight, ButtonLeft};

    // Level flips only after the synchronized input disagrees for DEBOUNCE_CYCLES straight cycles.
    for (genvar g = 0; g < 5; g++) begin : g_deb
        logic          sync1_q, sync2_q, level_q, press_q;
        logic [DW-1:0] cnt_q;

        always_ff @(posedge MasterClock or negedge ResetN) begin
            if (!ResetN) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= raw_btn[g];
                sync2_q <= sync1_q;
                press_q <= 1'b0;
                if (sync2_q == level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DW'(DEBOUNCE_CYCLES-1)) begin
                    cnt_q   <= '0;
                    level_q <= ~level_q;
                    press_q <= ~level_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign level[g] = level_q;
        assign press[g] = press_q;
    end

    function automatic logic [BW-1:0] cell_idx(input logic [VW-1:0] v, input logic [HW-1:0] h);
        return BW'((32'(v) * GRID_WIDTH + 32'(h)) * 2);
    endfunction

    logic [15:0]   lfsr_q, lfsr_d;
    logic [VW-1:0] nf_v_q, nf_v_d, cand_v;
    logic [HW-1:0] nf_h_q, nf_h_d, cand_h;
    logic          nf_valid_q, nf_valid_d;
    logic          fb, cand_in, cand_ok, held_empty;
    logic [BW-1:0] cand_idx;

    always_comb begin
        fb         = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10] ^ (|raw_btn);
        lfsr_d     = (lfsr_q == '0) ? LFSR_SEED : {lfsr_q[14:0], fb};
        cand_v     = VW'(lfsr_q[4:0]);
        cand_h     = HW'(lfsr_q[12:8]);
        cand_in    = (32'(cand_v) < GRID_HEIGHT) && (32'(cand_h) < GRID_WIDTH);
        // Out-of-grid candidates index cell 0 only to keep the select in range; cand_in masks them.
        cand_idx   = cand_in ? cell_idx(cand_v, cand_h) : '0;
        cand_ok    = cand_in && (Blocks[cand_idx +: 2] == 2'b00);
        held_empty = (Blocks[cell_idx(nf_v_q, nf_h_q) +: 2] == 2'b00);
        nf_v_d     = nf_v_q;
        nf_h_d     = nf_h_q;
        nf_valid_d = nf_valid_q;
        if (cand_ok) begin
            nf_v_d     = cand_v;
            nf_h_d     = cand_h;
            nf_valid_d = 1'b1;
        end else if (!held_empty) begin
            nf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge MasterClock or negedge ResetN) begin
        if (!ResetN) begin
            lfsr_q     <= LFSR_SEED;
            nf_v_q     <= '0;
            nf_h_q     <= '0;
            nf_valid_q <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            nf_v_q     <= nf_v_d;
            nf_h_q     <= nf_h_d;
            nf_valid_q <= nf_valid_d;
        end
    end

    assign {FastClock, GameClock, DebounceClock} = div_clk;
    assign {CenterPressed, DownPressed, UpPressed, RightPressed, LeftPressed} = press;
    assign {CenterLevel, DownLevel, UpLevel, RightLevel, LeftLevel} = level;
    assign NextFoodV     = nf_v_q;
    assign NextFoodH     = nf_h_q;
    assign NextFoodValid = nf_valid_q;

endmodule

// File: tb/tb_snake_timing_input_food.sv
// Directed bench for snake_timing_input_food: dividers, debouncers, food proposer, async reset.
module tb_snake_timing_input_food;

    localparam int unsigned GW = 32;
    localparam int unsigned GH = 24;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic b_left = 1'b0, b_right = 1'b0, b_up = 1'b0, b_down = 1'b0, b_center = 1'b0;
    logic [2*GW*GH-1:0] blocks = '0;
    logic deb_clk, game_clk, fast_clk;
    logic l_p, r_p, u_p, d_p, c_p;
    logic l_l, r_l, u_l, d_l, c_l;
    logic [4:0] nf_v, nf_h;
    logic nf_valid;

    snake_timing_input_food #(
        .PIX_DIV(4), .GAME_DIV(10), .FAST_DIV(6), .DEBOUNCE_CYCLES(8),
        .GRID_WIDTH(GW), .GRID_HEIGHT(GH), .LFSR_SEED(SEED)
    ) dut (
        .MasterClock(clk), .ResetN(rst_n),
        .ButtonLeft(b_left), .ButtonRight(b_right), .ButtonUp(b_up),
        .ButtonDown(b_down), .ButtonCenter(b_center),
        .Blocks(blocks),
        .DebounceClock(deb_clk), .GameClock(game_clk), .FastClock(fast_clk),
        .LeftPressed(l_p), .RightPressed(r_p), .UpPressed(u_p),
        .DownPressed(d_p), .CenterPressed(c_p),
        .LeftLevel(l_l), .RightLevel(r_l), .UpLevel(u_l),
        .DownLevel(d_l), .CenterLevel(c_l),
        .NextFoodV(nf_v), .NextFoodH(nf_h), .NextFoodValid(nf_valid)
    );

    always #5 clk = ~clk;

    logic [4:0]  pr;
    logic [23:0] all_outs;
    assign pr       = {l_p, r_p, u_p, d_p, c_p};
    assign all_outs = {deb_clk, game_clk, fast_clk, pr, l_l, r_l, u_l, d_l, c_l, nf_valid, nf_v, nf_h};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        {b_left, b_right, b_up, b_down, b_center} = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [15:0] m_lfsr;
    logic        m_valid;
    logic [4:0]  m_v, m_h;

    task automatic model_reset();
        m_lfsr  = SEED;
        m_valid = 1'b0;
        m_v     = '0;
        m_h     = '0;
    endtask

    // Empty grid and idle buttons: any candidate with row < GH is accepted.
    task automatic model_step();
        logic fbit;
        if (m_lfsr[4:0] < 5'(GH)) begin
            m_valid = 1'b1;
            m_v     = m_lfsr[4:0];
            m_h     = m_lfsr[12:8];
        end
        fbit   = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
        m_lfsr = (m_lfsr == 16'h0) ? SEED : {m_lfsr[14:0], fbit};
    endtask

    task automatic run_food_model(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            model_step();
            check(tag, {21'b0, nf_valid, nf_v, nf_h}, {21'b0, m_valid, m_v, m_h});
        end
    endtask

    initial begin
        logic seen;
        logic found;

        // Reset state and divider waveforms
        do_reset();
        check("reset_state", {8'b0, all_outs}, 32'h0);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check("dividers", {29'b0, deb_clk, game_clk, fast_clk},
                  {29'b0, ((k/2)%2) != 0, ((k/5)%2) != 0, ((k/3)%2) != 0});
        end

        // Short press of 5 cycles is rejected
        do_reset();
        b_up = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            seen = seen | u_l | u_p;
            if (k == 5) b_up = 1'b0;
        end
        check("deb_glitch", {31'b0, seen}, 32'h0);

        // Clean 20-cycle press: level at cycle 10, single pulse, no pulse on release
        do_reset();
        b_up = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check("deb_up", {26'b0, pr, u_l},
                  {26'b0, (k == 10) ? 5'b00100 : 5'b00000, (k >= 10) && (k < 30)});
            if (k == 20) b_up = 1'b0;
        end

        // Simultaneous presses on independent buttons
        do_reset();
        b_left = 1'b1; b_right = 1'b1; b_down = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("deb_simul", {27'b0, pr}, {27'b0, (k == 10) ? 5'b11010 : 5'b00000});
        end

        // Bouncing center button, final rise before cycle 31
        do_reset();
        b_center = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            check("deb_bounce", {26'b0, pr, c_l},
                  {26'b0, (k == 40) ? 5'b00001 : 5'b00000, k >= 40});
            b_center = (k < 30) ? (((k/3)%2) == 0) : 1'b1;
        end

        // Empty grid: food sequence from seed
        blocks = '0;
        do_reset();
        model_reset();
        run_food_model("food_empty", 40);
        check("food_v_range", {31'b0, nf_v < 5'd24}, 32'h1);

        // Asynchronous reset while GameClock high, then identical sequence
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (game_clk) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("game_clk_high_wait", {31'b0, found}, 32'h1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {8'b0, all_outs}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        run_food_model("food_after_reset", 40);

        // Single empty cell [5][5] in a walled grid
        blocks = {(GW*GH){2'b01}};
        blocks[(5*GW+5)*2 +: 2] = 2'b00;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (nf_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("food_one_found", {31'b0, found}, 32'h1);
        check("food_one_v", {27'b0, nf_v}, 32'd5);
        check("food_one_h", {27'b0, nf_h}, 32'd5);
        blocks[(5*GW+5)*2 +: 2] = 2'b10;
        @(negedge clk);
        check("food_occupied_valid", {31'b0, nf_valid}, 32'h0);
        check("food_stale_coords", {22'b0, nf_v, nf_h}, {22'b0, 5'd5, 5'd5});

        // Grid now full: valid must stay low
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            seen = seen | nf_valid;
        end
        check("food_full_grid", {31'b0, seen}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
